buf_ring_flag: RTL and testbench

- N-deep ring-buffer ownership tracker. It generalises the two-entry ping-pong flag pair to NBUF buffers with explicit write/read indices, occupancy count, ready/valid status, error capture and an optional overwrite-oldest mode.
- Sits between a frame writer (e.g. line/frame capture) and a reader (e.g. bilinear scaler). It tells each side which buffer to use and when.

---
 rtl/buf_pkg.sv | 39 +++
 rtl/buf_ring_ptr.sv | 41 ++++
 rtl/buf_ring_flag.sv | 172 +++++++++++++++++
 tb/tb_buf_ring_flag.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/buf_pkg.sv
// -----------------------------------------------------------------------------
// buf_pkg
// Shared helpers for the ring-buffer ownership managers.
//   NBUF_MAX   : largest supported buffer count
//   IDX_MAX_W  : index width needed for NBUF_MAX buffers
//   clog2_min1 : ceil(log2(n)), never less than 1 (a 1-deep ring still
//                gets a 1-bit index)
//   ptr_inc    : wrap-aware index increment, correct for any n (no modulo)
// -----------------------------------------------------------------------------
package buf_pkg;

  localparam int NBUF_MAX  = 16;
  localparam int IDX_MAX_W = 4;

  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 6; i++) begin
      if (int'(32'd1 << i) < n) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  function automatic logic [IDX_MAX_W-1:0] ptr_inc(input logic [IDX_MAX_W-1:0] idx,
                                                   input int n);
    logic [IDX_MAX_W-1:0] res;
    if ({{(32-IDX_MAX_W){1'b0}}, idx} == 32'(n - 1)) begin
      res = {IDX_MAX_W{1'b0}};
    end else begin
      res = idx + {{(IDX_MAX_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/buf_ring_ptr.sv
// -----------------------------------------------------------------------------
// buf_ring_ptr
// Registered ring index that steps to the next buffer (with wrap at NBUF-1)
// whenever en is high.
//   clk : system clock
//   rst : asynchronous active-high reset (index -> 0)
//   clr : synchronous flush (index -> 0), has priority over en
//   en  : advance the index by one buffer this cycle
//   idx : current index
// -----------------------------------------------------------------------------
module buf_ring_ptr
  import buf_pkg::*;
#(
  parameter int NBUF = 4,
  parameter int IW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] idx_r;

  // index register: reset/flush to buffer 0, otherwise step on enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r <= {IW{1'b0}};
    end else if (clr) begin
      idx_r <= {IW{1'b0}};
    end else if (en) begin
      idx_r <= IW'(ptr_inc(IDX_MAX_W'(idx_r), NBUF));
    end else begin
      idx_r <= idx_r;
    end
  end

  assign idx = idx_r;

endmodule

// File: rtl/buf_ring_flag.sv
// -----------------------------------------------------------------------------
// buf_ring_flag
// N-deep ring-buffer ownership tracker between a frame writer and a reader.
// Tells the writer which buffer to fill next and the reader which buffer to
// consume next, tracks occupancy and captures protocol errors.
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   clr        : synchronous flush to the reset state (beats any release)
//   wr_rls     : pulse, writer finished buffer wr_idx
//   rd_rls     : pulse, reader finished buffer rd_idx
//   wr_idx     : buffer the writer must fill next
//   rd_idx     : buffer the reader must consume next
//   buf_flag   : bit i set while buffer i holds committed, unread data
//   fill_cnt   : number of committed buffers (0..NBUF)
//   wr_rdy     : room for a write (always 1 in overwrite mode)
//   rd_vld     : at least one committed buffer
//   ovf        : sticky, a write release was dropped (OVERWRITE=0)
//   udf        : sticky, a read release arrived while empty
//   drop_pulse : one-cycle pulse, oldest buffer discarded (OVERWRITE=1)
// -----------------------------------------------------------------------------
module buf_ring_flag
  import buf_pkg::*;
#(
  parameter  int NBUF      = 4,
  parameter  int OVERWRITE = 0,
  localparam int IW        = clog2_min1(NBUF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            wr_rls,
  input  logic            rd_rls,
  output logic [IW-1:0]   wr_idx,
  output logic [IW-1:0]   rd_idx,
  output logic [NBUF-1:0] buf_flag,
  output logic [IW:0]     fill_cnt,
  output logic            wr_rdy,
  output logic            rd_vld,
  output logic            ovf,
  output logic            udf,
  output logic            drop_pulse
);

  localparam logic [IW:0] FULL_CNT = (IW+1)'(NBUF);

  logic [IW:0]     fill_cnt_r;
  logic [NBUF-1:0] buf_flag_r;
  logic            ovf_r;
  logic            udf_r;
  logic            drop_r;

  logic            full_s;
  logic            empty_s;
  logic            wr_acc_s;
  logic            rd_acc_s;
  logic            drop_s;
  logic            ovf_set_s;
  logic            udf_set_s;
  logic [IW:0]     cnt_nxt_s;
  logic [NBUF-1:0] flag_nxt_s;

  assign full_s  = (fill_cnt_r == FULL_CNT);
  assign empty_s = (fill_cnt_r == {(IW+1){1'b0}});

  // release arbitration: decide which releases are accepted and which errors fire
  always_comb begin
    wr_acc_s  = 1'b0;
    rd_acc_s  = 1'b0;
    drop_s    = 1'b0;
    ovf_set_s = 1'b0;
    udf_set_s = 1'b0;
    if (wr_rls && rd_rls) begin
      // the write always fits: either there is room, or the read frees one
      wr_acc_s = 1'b1;
      if (empty_s) begin
        udf_set_s = 1'b1;
      end else begin
        rd_acc_s = 1'b1;
      end
    end else if (wr_rls) begin
      if (!full_s) begin
        wr_acc_s = 1'b1;
      end else if (OVERWRITE != 0) begin
        // discard the oldest: the write reuses the slot the reader would take
        wr_acc_s = 1'b1;
        rd_acc_s = 1'b1;
        drop_s   = 1'b1;
      end else begin
        ovf_set_s = 1'b1;
      end
    end else if (rd_rls) begin
      if (!empty_s) begin
        rd_acc_s = 1'b1;
      end else begin
        udf_set_s = 1'b1;
      end
    end else begin
      wr_acc_s = 1'b0;
    end
  end

  // next occupancy and flag vector from the accepted releases
  always_comb begin
    cnt_nxt_s  = fill_cnt_r + (IW+1)'(wr_acc_s) - (IW+1)'(rd_acc_s);
    flag_nxt_s = buf_flag_r;
    if (rd_acc_s) begin
      flag_nxt_s[rd_idx] = 1'b0;
    end else begin
      flag_nxt_s = flag_nxt_s;
    end
    // set after clear so a full-ring write onto the read slot keeps the flag
    if (wr_acc_s) begin
      flag_nxt_s[wr_idx] = 1'b1;
    end else begin
      flag_nxt_s = flag_nxt_s;
    end
  end

  // occupancy, flags and error state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt_r <= {(IW+1){1'b0}};
      buf_flag_r <= {NBUF{1'b0}};
      ovf_r      <= 1'b0;
      udf_r      <= 1'b0;
      drop_r     <= 1'b0;
    end else if (clr) begin
      fill_cnt_r <= {(IW+1){1'b0}};
      buf_flag_r <= {NBUF{1'b0}};
      ovf_r      <= 1'b0;
      udf_r      <= 1'b0;
      drop_r     <= 1'b0;
    end else begin
      fill_cnt_r <= cnt_nxt_s;
      buf_flag_r <= flag_nxt_s;
      ovf_r      <= ovf_r | ovf_set_s;
      udf_r      <= udf_r | udf_set_s;
      drop_r     <= drop_s;
    end
  end

  buf_ring_ptr #(
    .NBUF (NBUF),
    .IW   (IW)
  ) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (wr_acc_s),
    .idx (wr_idx)
  );

  buf_ring_ptr #(
    .NBUF (NBUF),
    .IW   (IW)
  ) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (rd_acc_s),
    .idx (rd_idx)
  );

  assign fill_cnt   = fill_cnt_r;
  assign buf_flag   = buf_flag_r;
  assign ovf        = ovf_r;
  assign udf        = udf_r;
  assign drop_pulse = drop_r;
  assign wr_rdy     = (fill_cnt_r != FULL_CNT) || (OVERWRITE != 0);
  assign rd_vld     = !empty_s;

endmodule

// File: tb/tb_buf_ring_flag.sv
// -----------------------------------------------------------------------------
// tb_buf_ring_flag
// Runs several NBUF/OVERWRITE configurations side by side. Each configuration
// keeps a queue-of-buffer-indices reference model; every stimulus step pushes
// the expected post-edge state into a scoreboard queue that a per-config
// monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_buf_ring_flag;

  localparam int NCFG     = 8;
  localparam int RAND_CYC = 10000;
  localparam int TIMEOUT  = 400000;

  typedef struct {
    logic [15:0] flag;
    int          fill;
    int          wr;
    int          rd;
    int          wr_rdy;
    int          rd_vld;
    int          ovf;
    int          udf;
    int          drop;
  } exp_t;

  function automatic int cfg_nbuf(input int g);
    case (g)
      0: return 4;
      1: return 4;
      2: return 1;
      3: return 2;
      4: return 3;
      5: return 5;
      6: return 8;
      default: return 3;
    endcase
  endfunction

  function automatic int cfg_ow(input int g);
    case (g)
      1, 5, 7: return 1;
      default: return 0;
    endcase
  endfunction

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int g, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got %0d expected %0d at %0t", g, nm, act, exp, $time);
    end
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int NB  = cfg_nbuf(g);
    localparam int OW  = cfg_ow(g);
    localparam int IWL = buf_pkg::clog2_min1(NB);

    logic           rst = 1'b0;
    logic           clr = 1'b0;
    logic           wr_rls = 1'b0;
    logic           rd_rls = 1'b0;
    logic [IWL-1:0] wr_idx;
    logic [IWL-1:0] rd_idx;
    logic [NB-1:0]  buf_flag;
    logic [IWL:0]   fill_cnt;
    logic           wr_rdy;
    logic           rd_vld;
    logic           ovf;
    logic           udf;
    logic           drop_pulse;

    buf_ring_flag #(.NBUF(NB), .OVERWRITE(OW)) dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .wr_rls     (wr_rls),
      .rd_rls     (rd_rls),
      .wr_idx     (wr_idx),
      .rd_idx     (rd_idx),
      .buf_flag   (buf_flag),
      .fill_cnt   (fill_cnt),
      .wr_rdy     (wr_rdy),
      .rd_vld     (rd_vld),
      .ovf        (ovf),
      .udf        (udf),
      .drop_pulse (drop_pulse)
    );

    // reference model: committed buffers in age order, plus next write slot
    int   m_fifo[$];
    int   m_wr = 0;
    int   m_ovf = 0;
    int   m_udf = 0;
    int   m_drop = 0;
    exp_t q[$];
    exp_t mon_e;

    task automatic step(input bit r, input bit c, input bit w, input bit d);
      exp_t e;
      @(negedge clk);
      #1;
      rst    = r;
      clr    = c;
      wr_rls = w;
      rd_rls = d;
      m_drop = 0;
      if (r || c) begin
        m_fifo.delete();
        m_wr  = 0;
        m_ovf = 0;
        m_udf = 0;
      end else if (w && d) begin
        if (m_fifo.size() == 0) m_udf = 1;
        else void'(m_fifo.pop_front());
        m_fifo.push_back(m_wr);
        m_wr = (m_wr + 1) % NB;
      end else if (w) begin
        if (m_fifo.size() < NB) begin
          m_fifo.push_back(m_wr);
          m_wr = (m_wr + 1) % NB;
        end else if (OW != 0) begin
          void'(m_fifo.pop_front());
          m_fifo.push_back(m_wr);
          m_wr   = (m_wr + 1) % NB;
          m_drop = 1;
        end else begin
          m_ovf = 1;
        end
      end else if (d) begin
        if (m_fifo.size() > 0) void'(m_fifo.pop_front());
        else m_udf = 1;
      end
      e.flag = '0;
      foreach (m_fifo[i]) e.flag[m_fifo[i]] = 1'b1;
      e.fill   = m_fifo.size();
      e.wr     = m_wr;
      e.rd     = (m_fifo.size() == 0) ? m_wr : m_fifo[0];
      e.wr_rdy = (m_fifo.size() != NB || OW != 0) ? 1 : 0;
      e.rd_vld = (m_fifo.size() != 0) ? 1 : 0;
      e.ovf    = m_ovf;
      e.udf    = m_udf;
      e.drop   = m_drop;
      q.push_back(e);
    endtask

    // monitor: compare DUT state against the oldest pending expectation
    always @(negedge clk) begin
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("buf_flag",   g, int'(buf_flag),   int'(mon_e.flag));
        chk("fill_cnt",   g, int'(fill_cnt),   mon_e.fill);
        chk("wr_idx",     g, int'(wr_idx),     mon_e.wr);
        chk("rd_idx",     g, int'(rd_idx),     mon_e.rd);
        chk("wr_rdy",     g, int'(wr_rdy),     mon_e.wr_rdy);
        chk("rd_vld",     g, int'(rd_vld),     mon_e.rd_vld);
        chk("ovf",        g, int'(ovf),        mon_e.ovf);
        chk("udf",        g, int'(udf),        mon_e.udf);
        chk("drop_pulse", g, int'(drop_pulse), mon_e.drop);
        chk("popcount",   g, $countones(buf_flag), int'(fill_cnt));
        chk("idx_equal",  g,
            int'((wr_idx == rd_idx) && (int'(fill_cnt) != 0) && (int'(fill_cnt) != NB)), 0);
      end
    end

    initial begin
      int pw;
      bit r, c, w, d;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_wr_rdy", g, int'(wr_rdy), 1);
      chk("rst_rd_vld", g, int'(rd_vld), 0);
      // fill to full
      for (int i = 0; i < NB; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("full_fill", g, int'(fill_cnt), NB);
      chk("full_flag", g, int'(buf_flag), (1 << NB) - 1);
      chk("full_wr_idx", g, int'(wr_idx), 0);
      chk("full_wr_rdy", g, int'(wr_rdy), (OW != 0) ? 1 : 0);
      // one write too many
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("extra_ovf",  g, int'(ovf),        (OW == 0) ? 1 : 0);
      chk("extra_drop", g, int'(drop_pulse), (OW != 0) ? 1 : 0);
      chk("extra_fill", g, int'(fill_cnt),   NB);
      // drain and one read too many
      for (int i = 0; i < NB + 1; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("drain_udf",  g, int'(udf),    1);
      chk("drain_vld",  g, int'(rd_vld), 0);
      // simultaneous releases when empty, then at partial fill and when full
      step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < NB; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      // reset mid-stream, then flush colliding with a write
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("clr_fill",   g, int'(fill_cnt), 0);
      chk("clr_wr_idx", g, int'(wr_idx),   0);
      // random traffic, phases biased toward full, toward empty, and balanced
      for (int i = 0; i < RAND_CYC; i++) begin
        case ((i / 300) % 3)
          0:       pw = 80;
          1:       pw = 20;
          default: pw = 50;
        endcase
        w = int'($urandom_range(99)) < pw;
        d = int'($urandom_range(99)) < (100 - pw);
        c = ($urandom_range(499) == 0);
        r = ($urandom_range(699) == 0);
        step(r, c, w, d);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #2;
      chk("sb_drained", g, q.size(), 0);
      done_cnt++;
    end
  end

  initial begin
    fork
      wait (done_cnt == NCFG);
      #(TIMEOUT);
    join_any
    disable fork;
    if (done_cnt != NCFG) begin
      checks++;
      errors++;
      $display("FAIL timeout: done %0d expected %0d", done_cnt, NCFG);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
